// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the mult32x32 arbiter slice.
package mult_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int OP_W        = 32;
  localparam int PROD_W      = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr_i, with wrap.
module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_valid_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Modulo keeps the scan in range when NUM_REQ is not a power of two.
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_o[idx]  = 1'b1;
        winner_o      = idx;
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/mult32x32_arbiter.sv
// Round-robin sharing of one 32x32 multiplier between NUM_REQ requesters.
// Optional MULT_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier and respond directly.
module mult32x32_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    mult_start,
  output logic [OP_W-1:0]         mult_a,
  output logic [OP_W-1:0]         mult_b,
  input  logic                    mult_busy,
  input  logic [PROD_W-1:0]       mult_product,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    arb_busy,
  output arb_state_t              dbg_state_o,
  output logic [ID_W-1:0]         dbg_rr_ptr_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // ready never depends on valid of the same channel beyond the arbitration pick.

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]     mult_a_q, mult_a_d;
  logic [OP_W-1:0]     mult_b_q, mult_b_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0]   rsp_product_q, rsp_product_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     winner;
  logic                any_valid;
  logic [OP_W-1:0]     sel_a, sel_b;
  logic                zero_hit;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i       (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_a = req_a[k*OP_W +: OP_W];
        sel_b = req_b[k*OP_W +: OP_W];
      end
    end
  end

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_hit = (sel_a == '0) || (sel_b == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          rsp_id_d = winner;
          rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
          if (zero_hit) begin
            rsp_product_d = '0;
            state_d       = RESP;
          end else begin
            mult_a_d = sel_a;
            mult_b_d = sel_b;
            state_d  = START;
          end
        end
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (mult_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!mult_busy) begin
          rsp_product_d = mult_product;
          state_d       = RESP;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  // Grant is only offered while idle and out of reset.
  assign req_ready    = (state_q == IDLE && reset) ? grant : '0;
  assign mult_start   = (state_q == START);
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_product  = rsp_product_q;
  assign arb_busy     = (state_q != IDLE);
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed plus randomized bench for mult32x32_arbiter with a behavioural multiplier and reference model.
`timescale 1ns/1ps
module tb_mult32x32_arbiter;
  import mult_arb_pkg::*;

  localparam int N = 4;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            mult_start;
  logic [31:0]     mult_a, mult_b;
  logic            mult_busy = 1'b0;
  logic [63:0]     mult_product = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_product;
  logic            arb_busy;
  arb_state_t      dbg_state;
  logic [1:0]      dbg_rr_ptr;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  int          id_q[$];
  int          rr_m = 0;
  int          busy_len = 1;
  int          start_cnt = 0;
  int          busy_left = 0;
  logic [63:0] pend = '0;
  logic [31:0] a_v[N];
  logic [31:0] b_v[N];

  mult32x32_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .arb_busy     (arb_busy),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Behavioural multiplier: busy from the cycle after start for busy_len cycles; junk product while busy.
  always @(posedge clk) begin
    if (mult_start) begin
      start_cnt    <= start_cnt + 1;
      mult_busy    <= 1'b1;
      busy_left    <= busy_len - 1;
      pend         <= 64'(mult_a) * 64'(mult_b);
      mult_product <= 64'hBAD0_BAD0_BAD0_BAD0;
    end else if (mult_busy) begin
      if (busy_left == 0) begin
        mult_busy    <= 1'b0;
        mult_product <= pend;
      end else begin
        busy_left <= busy_left - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit bypass(input logic [31:0] a, input logic [31:0] b);
    return BYPASS && (a == 32'd0 || b == 32'd0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_arb_busy", 64'(arb_busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mult_start", 64'(mult_start), 64'd0);
    check("rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    check("rst_rsp_product", rsp_product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rr_m = 0;
    exp_q.delete();
    id_q.delete();
  endtask

  task automatic run_op(input logic [N-1:0] valid, input int busy_n, input int hold);
    int w;
    int lat;
    int s0;
    bit byp;
    logic [N-1:0] oh;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = a_v[i];
      req_b[i*32 +: 32] = b_v[i];
    end
    req_valid = valid;
    busy_len = busy_n;
    #1;
    w = pick(valid, rr_m);
    oh = '0;
    oh[w] = 1'b1;
    check("req_ready_grant", 64'(req_ready), 64'(oh));
    byp = bypass(a_v[w], b_v[w]);
    exp_q.push_back(64'(a_v[w]) * 64'(b_v[w]));
    id_q.push_back(w);
    s0 = start_cnt;
    @(posedge clk);
    rr_m = (w + 1) % N;
    lat = 1;
    @(negedge clk);
    if (!byp) begin
      check("mult_start_pulse", 64'(mult_start), 64'd1);
      check("mult_a", 64'(mult_a), 64'(a_v[w]));
      check("mult_b", 64'(mult_b), 64'(b_v[w]));
    end
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), byp ? 64'd1 : 64'(3 + busy_n));
    check("start_count", 64'(start_cnt - s0), byp ? 64'd0 : 64'd1);
    check("arb_busy_resp", 64'(arb_busy), 64'd1);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'(id_q[0]));
      check("hold_product", rsp_product, exp_q[0]);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    check("hold_start_count", 64'(start_cnt - s0), byp ? 64'd0 : 64'd1);
    rsp_ready = 1'b1;
    check("rsp_id", 64'(rsp_id), 64'(id_q.pop_front()));
    check("rsp_product", rsp_product, exp_q.pop_front());
    check("req_ready_hs", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("arb_busy_idle", 64'(arb_busy), 64'd0);
  endtask

  initial begin
    logic [N-1:0] v;
    do_reset();

    // Single request
    a_v[0] = 32'd7;
    b_v[0] = 32'd6;
    run_op(4'b0001, 2, 0);

    // Contention from a fresh pointer: expected order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(i + 1);
      b_v[i] = 32'h0001_0000;
    end
    for (int t = 0; t < 5; t++) begin
      check("contention_order", 64'(pick(4'hF, rr_m)), 64'(t % N));
      run_op(4'hF, 1 + $urandom_range(0, 2), 0);
    end

    // Backpressure
    a_v[3] = 32'd1000;
    b_v[3] = 32'd3;
    run_op(4'b1000, 3, 10);

    // Full-width operands
    a_v[1] = 32'hFFFF_FFFF;
    b_v[1] = 32'hFFFF_FFFF;
    check("full_width_model", 64'(a_v[1]) * 64'(b_v[1]), 64'hFFFF_FFFE_0000_0001);
    run_op(4'b0010, 1, 0);

    // rsp_ready without rsp_valid
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_ready_valid", 64'(rsp_valid), 64'd0);
    check("stray_ready_busy", 64'(arb_busy), 64'd0);
    rsp_ready = 1'b0;

    // Reset during WAIT_LO
    @(negedge clk);
    req_a[31:0] = 32'd9;
    req_b[31:0] = 32'd9;
    req_valid = 4'b0001;
    busy_len = 6;
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_state_wait_lo", 64'(dbg_state), 64'(WAIT_LO));
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_arb_busy", 64'(arb_busy), 64'd0);
    check("mid_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
    rr_m = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("busy_in_idle_ignored", 64'(arb_busy), 64'd0);
    end
    a_v[2] = 32'd3;
    b_v[2] = 32'd5;
    run_op(4'b0100, 2, 1);

    // Zero operand
    a_v[1] = 32'd0;
    b_v[1] = 32'h1234;
    run_op(4'b0010, 2, 0);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      v = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       a_v[i] = 32'd0;
          1:       a_v[i] = 32'hFFFF_FFFF;
          default: a_v[i] = $urandom;
        endcase
        case ($urandom_range(0, 5))
          0:       b_v[i] = 32'd0;
          1:       b_v[i] = 32'hFFFF_FFFF;
          default: b_v[i] = $urandom;
        endcase
      end
      run_op(v, $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult32x32_arbiter.md
Name: mult32x32_arbiter

Overview:
- Shares one mult32x32_fast instance between NUM_REQ independent requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and picks one requester round-robin.
- Sequences the multiplier's start/busy protocol and returns the 64-bit product with the requester ID over a valid/ready response channel.
- One operation in flight at a time; sits between client blocks and the multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*32  packed operand a; slice i = [32*i+31:32*i].
- req_b  in  NUM_REQ*32  packed operand b, same packing.
- req_ready  out  NUM_REQ  one-hot grant/accept; request i transfers when req_valid[i] && req_ready[i].
- mult_start  out  1  single-cycle start pulse to the multiplier.
- mult_a  out  32  latched operand a to the multiplier.
- mult_b  out  32  latched operand b to the multiplier.
- mult_busy  in  1  multiplier busy indication.
- mult_product  in  64  multiplier product.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_product  out  64  product a*b (unsigned).
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0, async) values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, mult_start=0, mult_a=0, mult_b=0.
  - rsp_valid=0, rsp_id=0, rsp_product=0, arb_busy=0.
- States: IDLE, START, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - req_ready is combinational. It is the one-hot round-robin winner among req_valid, searching from rr_ptr upward with wrap, and is 0 outside IDLE.
  - On transfer: latch operands into mult_a/mult_b and the winner index into rsp_id; rr_ptr <= (winner+1) mod NUM_REQ; go to START.
  - With no valid requests: stay in IDLE, rr_ptr unchanged.
- START: mult_start=1 for exactly this cycle; mult_a/mult_b are stable. Go to WAIT_HI.
- WAIT_HI:
  - Wait for mult_busy==1, then go to WAIT_LO.
  - The multiplier guarantees busy high at least one cycle, starting the cycle after start.
- WAIT_LO: when mult_busy==0, capture mult_product into rsp_product and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_product are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - No new request is accepted in the cycle of the response handshake; the next acceptance is one cycle later at the earliest.
- Latency: request accept to rsp_valid = 3 + (multiplier busy cycles) clocks.
- Fairness:
  - A requester continuously asserting valid is served at least once every NUM_REQ operations.
  - req_valid may drop before grant without side effects.
- Width rules:
  - Unsigned 32x32 -> 64 product; no truncation.
  - Indices wrap modulo NUM_REQ, including when NUM_REQ is not a power of two.
- Reset mid-operation: state returns to IDLE immediately and rsp_valid drops; the pending response is discarded.
- Protocol errors:
  - A mult_busy rise while in IDLE or RESP is ignored.
  - A rsp_ready high while rsp_valid is low has no effect.

Optional Feature:
- MULT_ARB_ZERO_BYPASS_EN defined:
  - In IDLE, if the winning request has a==0 or b==0, the transfer goes directly to RESP with rsp_product=0.
  - mult_start is not pulsed and the multiplier is untouched; response latency is 1 clock.
- Undefined: every request goes through START/WAIT_HI/WAIT_LO.

Decomposition:
- Package mult_arb_pkg:
  - state enum arb_state_t {IDLE, START, WAIT_HI, WAIT_LO, RESP}.
  - Default NUM_REQ constant.
  - Operand width (32) and product width (64) constants.
- Sub-module mult_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_valid.

Test Plan:
1. Single request: req0 a=7, b=6 with model busy high 2 cycles -> one mult_start pulse; rsp_valid with rsp_id=0, rsp_product=42, 5 clocks after accept.
2. Contention: all 4 requesters hold valid (a=i+1, b=0x10000) -> grants in order 0,1,2,3,0; products 0x10000, 0x20000, 0x30000, 0x40000.
3. Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_id/rsp_product stable; req_ready stays 0; no further mult_start.
4. Full-width operands: a=b=0xFFFFFFFF -> rsp_product=0xFFFFFFFE00000001.
5. Reset mid-operation: reset=0 during WAIT_LO -> asynchronously rsp_valid=0, arb_busy=0, rr_ptr=0; after release, a req2 a=3, b=5 completes with rsp_id=2, rsp_product=15.
6. Zero operand: req1 a=0, b=0x1234 -> with MULT_ARB_ZERO_BYPASS_EN, rsp_product=0 next cycle with no mult_start; without it, the full sequence runs and rsp_product=0.
